// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID pipeline register.
package if_id_pkg;

    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned PC_W_DEF    = 10;
    localparam int unsigned PC_ADJ_DEF  = 1;
    localparam int unsigned CNT_W_DEF   = 16;

    // One buffer slot at the default widths.
    typedef struct packed {
        logic                   valid;
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    pc;
    } entry_t;

    // Buffer occupancy is exactly {skid.valid, main.valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/if_id_skid_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register: valid/ready handshake with a two-entry skid buffer,
// flush, debug freeze, PC alignment and saturating flush/stall counters.
module if_id_skid
    import if_id_pkg::*;
#(
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned PC_ADJ  = PC_ADJ_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruc_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruc_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [CNT_W-1:0]   flush_count,
    output logic [CNT_W-1:0]   stall_count
);

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } slot_t;

    localparam logic [PC_W-1:0] PC_ADJ_V = PC_W'(PC_ADJ);

    slot_t      main_q, main_d;
    slot_t      skid_q, skid_d;
    slot_t      in_entry;
    buf_state_e state;
    logic       acc_in, acc_out;

    assign state    = buf_state_e'({skid_q.valid, main_q.valid});
    assign acc_in   = in_valid & in_ready & enable & ~flush;
    assign acc_out  = main_q.valid & out_ready & enable & ~flush;
    assign in_entry = '{valid: 1'b1, instr: instruc_in, pc: pc_in - PC_ADJ_V};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = '0;
            skid_d = '0;
        end else begin
            case (state)
                ST_EMPTY: if (acc_in) main_d = in_entry;
                ST_ONE: begin
                    if (acc_in && acc_out) main_d = in_entry;
                    else if (acc_in)       skid_d = in_entry;
                    else if (acc_out)      main_d = '0;
                end
                // in_ready is low while full, so draining never races an input beat.
                ST_FULL: begin
                    if (acc_out) begin
                        main_d = skid_q;
                        skid_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign in_ready    = ~skid_q.valid;
    assign out_valid   = main_q.valid;
    assign instruc_out = main_q.instr & {INSTR_W{main_q.valid}};
    assign pc_out      = main_q.pc & {PC_W{main_q.valid}};

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush),
        .count (flush_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (main_q.valid & ~out_ready & enable),
        .count (stall_count)
    );

endmodule
